// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per clock in RUN, result registered on completion.
// Optional build macro SEQ_SHIFTER_ROTATE_EN turns mode 2'b11 into rotate-left.
module seq_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   In,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [WIDTH-1:0]   work_q, work_nxt, step;
    logic [SHAMT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]         mode_q, mode_nxt;

    // Single-bit move of the working register for the captured mode.
    always_comb begin
        step = {work_q[WIDTH-2:0], 1'b0};
        case (mode_q)
            2'b01:   step = {1'b0, work_q[WIDTH-1:1]};
            2'b10:   step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11:   step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
`endif
            default: step = {work_q[WIDTH-2:0], 1'b0};
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state_q;
        work_nxt  = work_q;
        cnt_nxt   = cnt_q;
        mode_nxt  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_nxt  = In;
                    cnt_nxt   = shamt;
                    mode_nxt  = mode;
                    state_nxt = (shamt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                work_nxt = step;
                cnt_nxt  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered off the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            Out     <= '0;
        end else begin
            state_q <= state_nxt;
            work_q  <= work_nxt;
            cnt_q   <= cnt_nxt;
            mode_q  <= mode_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                Out <= work_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter at WIDTH=32.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] In;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [31:0] Out;

    int errors = 0;
    int checks = 0;
    int ndone;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .shamt (shamt),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .Out   (Out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present an operation for one edge (caller sits at a negedge), then scramble the inputs.
    task automatic go(input logic [31:0] a, input logic [4:0] s, input logic [1:0] m);
        start = 1'b1;
        In    = a;
        shamt = s;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        In    = $urandom;
        shamt = 5'($urandom);
        mode  = 2'($urandom);
    endtask

    // Wait (bounded) for done; lat0 is the cycle count already elapsed since the start cycle.
    task automatic wait_done(input int lat0, input logic [4:0] s, input logic [31:0] exp,
                             input string tag);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(s) + 32'd1);
        chk({tag, "_out"}, Out, exp);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic [1:0] m,
                          input logic [31:0] exp, input string tag);
        @(negedge clk);
        go(a, s, m);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(1, s, exp, tag);
    endtask

    // One cycle after completion: done gone, back in IDLE, result held.
    task automatic after_done(input logic [31:0] exp, input string tag);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, Out, exp);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        In    = '0;
        shamt = '0;
        mode  = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out", Out, 32'h0);
        rst = 1'b0;

        run_op(32'h0000_0001, 5'd4, 2'b00, 32'h0000_0010, "sll4");
        after_done(32'h0000_0010, "sll4");

        run_op(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, "sra31");
        after_done(32'hFFFF_FFFF, "sra31");
        run_op(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, "srl31");
        after_done(32'h0000_0001, "srl31");

        run_op(32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF, "zero_m0");
        after_done(32'hDEAD_BEEF, "zero_m0");
        run_op(32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, "zero_m1");
        run_op(32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF, "zero_m2");
        run_op(32'hDEAD_BEEF, 5'd0, 2'b11, 32'hDEAD_BEEF, "zero_m3");
        after_done(32'hDEAD_BEEF, "zero_m3");

        run_op(32'h8000_00F0, 5'd4, 2'b10, 32'hF800_000F, "sra_neg");
        run_op(32'h4000_0000, 5'd4, 2'b10, 32'h0400_0000, "sra_pos");
        run_op(32'hC000_0001, 5'd1, 2'b00, 32'h8000_0002, "sll_msb");
        after_done(32'h8000_0002, "sll_msb");

`ifdef SEQ_SHIFTER_ROTATE_EN
        run_op(32'h8000_0001, 5'd1, 2'b11, 32'h0000_0003, "rol1");
        run_op(32'h8000_0001, 5'd4, 2'b11, 32'h0000_0018, "rol4");
`else
        run_op(32'h8000_0001, 5'd1, 2'b11, 32'h0000_0002, "rol1");
        run_op(32'h8000_0001, 5'd4, 2'b11, 32'h0000_0010, "rol4");
`endif

        // Back-to-back: second start lands in the IDLE cycle right after DONE.
        run_op(32'h0000_0100, 5'd2, 2'b01, 32'h0000_0040, "b2b_a");
        run_op(32'h0000_0001, 5'd3, 2'b00, 32'h0000_0008, "b2b_b");
        after_done(32'h0000_0008, "b2b_b");

        // Start while busy with different operand must be ignored.
        @(negedge clk);
        go(32'hF000_0000, 5'd8, 2'b01);
        @(negedge clk);
        start = 1'b1;
        In    = 32'h1234_5678;
        shamt = 5'd0;
        mode  = 2'b00;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, 5'd8, 32'h00F0_0000, "busy_start");
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("busy_start_extra_done", 32'(ndone), 32'd0);
        chk("busy_start_hold", Out, 32'h00F0_0000);

        // Asynchronous reset two cycles into a long operation.
        @(negedge clk);
        go(32'h0000_0001, 5'd10, 2'b00);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out", Out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_out_after", Out, 32'h0);

        // Start presented together with reset release is taken on the first edge.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        go(32'h0000_0003, 5'd1, 2'b00);
        chk("post_rst_busy", 32'(busy), 32'd1);
        wait_done(1, 5'd1, 32'h0000_0006, "post_rst");
        after_done(32'h0000_0006, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, at least 2.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), width of the shift-amount port.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 In  input  WIDTH  operand, captured on the accepting edge.
REQ-007 shamt  input  SHAMT_W  shift amount, captured on the accepting edge.
REQ-008 mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration).
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 Out  output  WIDTH  result register; holds its value until the next completion.

Function
REQ-012 FSM states: IDLE, RUN, DONE, encoded in a state register.
REQ-013 IDLE with start=1: capture In, shamt and mode into internal registers; load counter with shamt; next state RUN if shamt!=0, else DONE.
REQ-014 RUN: each cycle, shift the working register by exactly 1 bit per mode and decrement the counter; on the cycle where the counter reaches 0, go to DONE.
REQ-015 SLL: insert 0 at bit 0; SRL: insert 0 at bit WIDTH-1; SRA: replicate the captured bit WIDTH-1.
REQ-016 DONE: Out <= working register, done=1 for exactly this one cycle, then IDLE unconditionally.
REQ-017 Latency: done is high in the cycle following the (shamt+1)th rising edge after the accepting edge's cycle, i.e. shamt+1 cycles after capture; shamt=0 gives a 1-cycle latency with Out equal to In.
REQ-018 start while busy=1 is ignored, with no queuing and no effect on the in-flight operation.
REQ-019 Changes on In, shamt or mode after capture do not affect the in-flight result.
REQ-020 start in IDLE in the cycle right after DONE is accepted normally, giving back-to-back throughput of one operation per shamt+2 cycles.
REQ-021 Out updates only in DONE; it is never partially updated during RUN.
REQ-022 Maximum shamt is WIDTH-1; there is no overflow or wrap of the counter.

Reset
REQ-023 rst=1 forces state to IDLE, busy=0, done=0, Out=0, and the counter and working register to 0, asynchronously, with no clock required.
REQ-024 rst asserted mid-RUN or in DONE aborts the operation; no done pulse is produced and Out reads 0.
REQ-025 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro SEQ_SHIFTER_ROTATE_EN defined: mode 11 = rotate left; each RUN step moves bit WIDTH-1 into bit 0.
REQ-027 Macro SEQ_SHIFTER_ROTATE_EN undefined: mode 11 executes as SLL, and no rotate logic is synthesised.

Verification
REQ-028 WIDTH=32; In=0x0000_0001, shamt=4, mode=00 -> done exactly 5 cycles after capture, Out=0x0000_0010.
REQ-029 In=0x8000_0000, shamt=31, mode=10 -> Out=0xFFFF_FFFF after 32 cycles; with mode=01 -> Out=0x0000_0001.
REQ-030 shamt=0, In=0xDEAD_BEEF, any mode -> done 1 cycle after capture, Out=0xDEAD_BEEF.
REQ-031 start pulsed while busy, with In changed to 0x1234_5678 -> in-flight result unaffected; a single done pulse; the second start not executed.
REQ-032 rst asserted two cycles into shamt=10 -> busy=0, done=0, Out=0 immediately; no later done pulse.
REQ-033 With SEQ_SHIFTER_ROTATE_EN: In=0x8000_0001, shamt=1, mode=11 -> Out=0x0000_0003; without it -> Out=0x0000_0002.
